bcd_display_scan: RTL

//  Display-side consumer of the count10 BCD digit chain. Accepts NUM_DIGITS packed BCD digits,

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_display_scan_if.sv | 25 ++
 rtl/bcd_to_seg.sv | 28 ++
 rtl/bcd_display_scan.sv | 102 ++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared seven-segment glyph constants for the BCD display path.
// All patterns are active-low and ordered {g,f,e,d,c,b,a}.
package bcd_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Bundle of digit inputs and display-pin outputs for the scanned display.
// The producer side (counter cascade / bench) uses master; the scanner uses slave.
interface bcd_display_scan_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic                    frame_start;

  modport master (
    output bcd_in, dp_in, blank,
    input  an_n, seg_n, dp_n, frame_start
  );

  modport slave (
    input  bcd_in, dp_in, blank,
    output an_n, seg_n, dp_n, frame_start
  );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes 10-15 are not valid BCD and are shown as a dash so a fault is visible.
module bcd_to_seg
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  // Look up the glyph for the incoming digit
  always_comb begin
    seg_n = SEG_DASH;
    case (digit)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode display driver for a chain of BCD digits.
// A prescaler paces the scan; the whole digit set is captured once per frame
// so a frame never mixes old and new counter values.
module bcd_display_scan
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  bcd_display_scan_if.slave  bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           next_idx;
  logic                    active;
  logic [4*NUM_DIGITS-1:0] snap_bcd;
  logic [4*NUM_DIGITS-1:0] next_bcd;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   next_dp;
  logic                    tick;
  logic                    wrap;
  logic [3:0]              cur_digit;
  logic [6:0]              decoded;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    lz_hide;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic                    frame_q;

  // Next scan position and the digit set it will show; a wrap captures fresh inputs
  always_comb begin
    tick      = (prescaler == PRE_LAST);
    wrap      = tick && (idx == IDX_LAST);
    next_idx  = idx;
    if (tick) begin
      next_idx = wrap ? '0 : idx + 1'b1;
    end
    next_bcd  = wrap ? bus.bcd_in : snap_bcd;
    next_dp   = wrap ? bus.dp_in  : snap_dp;
    cur_digit = next_bcd[{next_idx, 2'b00} +: 4];
    an_next   = ~(NUM_DIGITS'(1) << next_idx);
  end

  // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (next_bcd[4*NUM_DIGITS-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (next_bcd[4*i +: 4] == 4'd0);
    end
    lz_hide = LZ_BLANK && (next_idx != '0) && lead_zero[next_idx];
  end

  bcd_to_seg u_decode (
    .digit (cur_digit),
    .seg_n (decoded)
  );

  // Scan state and registered display pins; anodes follow blank every cycle, glyphs change on ticks
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      idx       <= IDX_LAST;
      active    <= 1'b0;
      snap_bcd  <= '0;
      snap_dp   <= '0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      idx       <= next_idx;
      snap_bcd  <= next_bcd;
      snap_dp   <= next_dp;
      if (tick) begin
        active <= 1'b1;
        seg_q  <= lz_hide ? SEG_BLANK : decoded;
        dp_q   <= ~next_dp[next_idx];
      end
      an_q    <= (bus.blank || !(active || tick)) ? '1 : an_next;
      frame_q <= tick && (next_idx == '0);
    end
  end

  assign bus.an_n        = an_q;
  assign bus.seg_n       = seg_q;
  assign bus.dp_n        = dp_q;
  assign bus.frame_start = frame_q;

endmodule
